// File: rtl/dtr_pkg.sv
// Shared types and constants for the DTR recovery controller.
package dtr_pkg;

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    NORMAL   = 3'd1,
    ROLLBACK = 3'd2,
    VERIFY   = 3'd3,
    FATAL    = 3'd4
  } dtrState_e;

  localparam int DTR_ROLL_CYC   = 3;
  localparam int DTR_INIT_CYC   = 3;
  localparam int DTR_VERIFY_CYC = 3;

  // Timer width able to hold the largest (count - 1) of the three phases.
  function automatic int timerWidth(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if ($clog2(m) < 1) return 1;
    else return $clog2(m);
  endfunction

endpackage

// File: rtl/dtr_recovery_ctrl_if.sv
// Control bundle between the recovery controller and the DTR interface blocks.
interface dtr_recovery_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             fail_in;
  logic             save;
  logic             rollBack;
  logic             subst;
  logic             busy;
  logic             fatal;
  logic [CNT_W-1:0] err_count;

  modport master (
    input  fail_in,
    output save, rollBack, subst, busy, fatal, err_count
  );

  modport slave (
    output fail_in,
    input  save, rollBack, subst, busy, fatal, err_count
  );
endinterface

// File: rtl/dtr_cycle_timer.sv
// Loadable down-counter that stops at zero and flags it.
module dtr_cycle_timer #(
  parameter int            TW      = 2,
  parameter logic [TW-1:0] RST_VAL = {TW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_s,
  input  logic [TW-1:0] loadVal_s,
  output logic          zero_s
);

  logic [TW-1:0] count_r;

  // Reload on request, otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= RST_VAL;
    end else if (load_s) begin
      count_r <= loadVal_s;
    end else if (count_r != {TW{1'b0}}) begin
      count_r <= count_r - {{(TW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero_s = (count_r == {TW{1'b0}});

endmodule

// File: rtl/dtr_recovery_ctrl.sv
// Save/rollback/substitute sequencer for the DTR interface blocks:
// checkpoint in NORMAL, replay on mismatch, verify, give up after retries.
module dtr_recovery_ctrl
  import dtr_pkg::*;
#(
  parameter int INIT_CYC   = DTR_INIT_CYC,
  parameter int ROLL_CYC   = DTR_ROLL_CYC,
  parameter int VERIFY_CYC = DTR_VERIFY_CYC,
  parameter int MAX_RETRY  = 2,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  dtr_recovery_ctrl_if.master bus
);

  localparam int            TW          = timerWidth(INIT_CYC, ROLL_CYC, VERIFY_CYC);
  localparam logic [TW-1:0] INIT_LOAD   = TW'(INIT_CYC - 1);
  localparam logic [TW-1:0] ROLL_LOAD   = TW'(ROLL_CYC - 1);
  localparam logic [TW-1:0] VERIFY_LOAD = TW'(VERIFY_CYC - 1);
  // retry+1 < MAX_RETRY is the same as retry < MAX_RETRY-1
  localparam logic [3:0]    RETRY_LAST  = 4'(MAX_RETRY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  dtrState_e        state_r;
  dtrState_e        stateNext_s;
  logic             timerLoad_s;
  logic [TW-1:0]    timerVal_s;
  logic             timerZero_s;
  logic [3:0]       retry_r;
  logic [3:0]       retryNext_s;
  logic             cntInc_s;
  logic [CNT_W-1:0] errCount_r;

  dtr_cycle_timer #(
    .TW      (TW),
    .RST_VAL (INIT_LOAD)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_s    (timerLoad_s),
    .loadVal_s (timerVal_s),
    .zero_s    (timerZero_s)
  );

  // Next-state decision; the timer is reloaded on every state change.
  always_comb begin
    stateNext_s = state_r;
    timerLoad_s = 1'b0;
    timerVal_s  = {TW{1'b0}};
    retryNext_s = retry_r;
    cntInc_s    = 1'b0;
    case (state_r)
      INIT: begin
        if (timerZero_s) begin
          stateNext_s = NORMAL;
          timerLoad_s = 1'b1;
        end else begin
          stateNext_s = INIT;
        end
      end
      NORMAL: begin
        if (bus.fail_in) begin
          stateNext_s = ROLLBACK;
          timerLoad_s = 1'b1;
          timerVal_s  = ROLL_LOAD;
        end else begin
          stateNext_s = NORMAL;
        end
      end
      ROLLBACK: begin
        if (timerZero_s) begin
          stateNext_s = VERIFY;
          timerLoad_s = 1'b1;
          timerVal_s  = VERIFY_LOAD;
        end else begin
          stateNext_s = ROLLBACK;
        end
      end
      VERIFY: begin
        // A failure on the last verify cycle still counts as a failure.
        if (bus.fail_in) begin
          if (retry_r < RETRY_LAST) begin
            retryNext_s = retry_r + 4'd1;
            stateNext_s = ROLLBACK;
            timerLoad_s = 1'b1;
            timerVal_s  = ROLL_LOAD;
          end else begin
            stateNext_s = FATAL;
            timerLoad_s = 1'b1;
          end
        end else if (timerZero_s) begin
          stateNext_s = NORMAL;
          timerLoad_s = 1'b1;
          retryNext_s = 4'd0;
          cntInc_s    = 1'b1;
        end else begin
          stateNext_s = VERIFY;
        end
      end
      FATAL: begin
        stateNext_s = FATAL;
      end
      default: begin
        stateNext_s = FATAL;
        timerLoad_s = 1'b1;
      end
    endcase
  end

  // State, counters and outputs registered together so outputs follow state with no glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= INIT;
      retry_r      <= 4'd0;
      errCount_r   <= {CNT_W{1'b0}};
      bus.save     <= 1'b0;
      bus.rollBack <= 1'b0;
      bus.subst    <= 1'b0;
      bus.busy     <= 1'b1;
      bus.fatal    <= 1'b0;
    end else begin
      state_r <= stateNext_s;
      retry_r <= retryNext_s;
      if (cntInc_s && (errCount_r != CNT_MAX)) begin
        errCount_r <= errCount_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        errCount_r <= errCount_r;
      end
      case (stateNext_s)
        NORMAL: begin
          bus.save     <= 1'b1;
          bus.rollBack <= 1'b0;
          bus.subst    <= 1'b0;
          bus.busy     <= 1'b0;
          bus.fatal    <= 1'b0;
        end
        ROLLBACK: begin
          bus.save     <= 1'b0;
          bus.rollBack <= 1'b1;
          bus.subst    <= 1'b1;
          bus.busy     <= 1'b1;
          bus.fatal    <= 1'b0;
        end
        INIT, VERIFY: begin
          bus.save     <= 1'b0;
          bus.rollBack <= 1'b0;
          bus.subst    <= 1'b0;
          bus.busy     <= 1'b1;
          bus.fatal    <= 1'b0;
        end
        default: begin
          bus.save     <= 1'b0;
          bus.rollBack <= 1'b0;
          bus.subst    <= 1'b0;
          bus.busy     <= 1'b1;
          bus.fatal    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.err_count = errCount_r;

endmodule

// File: tb/tb_dtr_recovery_ctrl.sv
// Scoreboard bench for dtr_recovery_ctrl (narrow counter to exercise saturation).
module tb_dtr_recovery_ctrl;

  localparam int CNT_W      = 2;
  localparam int INIT_CYC   = 3;
  localparam int ROLL_CYC   = 3;
  localparam int VERIFY_CYC = 3;
  localparam int MAX_RETRY  = 2;

  localparam int M_INIT = 0, M_NORMAL = 1, M_RB = 2, M_VER = 3, M_FATAL = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  dtr_recovery_ctrl_if #(.CNT_W(CNT_W)) bus ();

  dtr_recovery_ctrl #(
    .INIT_CYC   (INIT_CYC),
    .ROLL_CYC   (ROLL_CYC),
    .VERIFY_CYC (VERIFY_CYC),
    .MAX_RETRY  (MAX_RETRY),
    .CNT_W      (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;

  logic [6:0] expQ[$];

  int mState = M_INIT;
  int mTimer = 0;
  int mRetry = 0;
  int mCnt   = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {save, rollBack, subst, busy, fatal, err_count} for the model state.
  function automatic logic [6:0] modelOut();
    logic [1:0] c;
    c = 2'(mCnt);
    case (mState)
      M_INIT:   return {5'b00010, c};
      M_NORMAL: return {5'b10000, c};
      M_RB:     return {5'b01110, c};
      M_VER:    return {5'b00010, c};
      default:  return {5'b00011, c};
    endcase
  endfunction

  task automatic modelEdge(input logic r, input logic f);
    if (r) begin
      mState = M_INIT; mTimer = INIT_CYC - 1; mRetry = 0; mCnt = 0;
    end else begin
      case (mState)
        M_INIT:   if (mTimer == 0) mState = M_NORMAL; else mTimer--;
        M_NORMAL: if (f) begin mState = M_RB; mTimer = ROLL_CYC - 1; end
        M_RB:     if (mTimer == 0) begin mState = M_VER; mTimer = VERIFY_CYC - 1; end
                  else mTimer--;
        M_VER: begin
          if (f) begin
            if (mRetry + 1 < MAX_RETRY) begin
              mRetry++; mState = M_RB; mTimer = ROLL_CYC - 1;
            end else begin
              mState = M_FATAL;
            end
          end else if (mTimer == 0) begin
            mState = M_NORMAL; mRetry = 0;
            if (mCnt < (1 << CNT_W) - 1) mCnt++;
          end else begin
            mTimer--;
          end
        end
        default: ;
      endcase
    end
  endtask

  // One clock: drive inputs, predict, then compare just after the falling edge.
  task automatic step(input logic r, input logic f);
    logic [6:0] e;
    rst = r;
    bus.fail_in = f;
    modelEdge(r, f);
    expQ.push_back(modelOut());
    @(posedge clk);
    @(negedge clk);
    cyc++;
    e = expQ.pop_front();
    checkVal($sformatf("outs_cyc%0d", cyc),
             {25'd0, bus.save, bus.rollBack, bus.subst, bus.busy, bus.fatal, bus.err_count},
             {25'd0, e});
  endtask

  task automatic recover();
    step(1'b0, 1'b1);
    repeat (7) step(1'b0, 1'b0);
  endtask

  int busyCnt;
  int rbSeen;
  logic [1:0] satExp [3] = '{2'd3, 2'd3, 2'd3};

  initial begin
    bus.fail_in = 1'b0;
    @(negedge clk);

    // Reset with fail_in held during INIT: busy for exactly 3 cycles.
    busyCnt = 0;
    rbSeen  = 0;
    step(1'b1, 1'b0);
    checkVal("reset_outs", {27'd0, bus.save, bus.rollBack, bus.subst, bus.busy, bus.fatal},
             32'h2);
    checkVal("reset_cnt", {30'd0, bus.err_count}, 32'd0);
    if (bus.busy) busyCnt++;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      if (bus.busy) busyCnt++;
      if (bus.rollBack) rbSeen++;
    end
    checkVal("init_busy_cycles", busyCnt, 32'd3);
    checkVal("init_no_rollback", rbSeen, 32'd0);
    checkVal("init_save_on", {31'd0, bus.save}, 32'd1);
    step(1'b0, 1'b0);

    // Single pulse: three rollback cycles then three verify cycles.
    step(1'b0, 1'b1);
    checkVal("pulse_rb", {30'd0, bus.rollBack, bus.save}, 32'h2);
    repeat (5) step(1'b0, 1'b0);
    checkVal("pulse_verify_end", {31'd0, bus.save}, 32'd0);
    step(1'b0, 1'b0);
    checkVal("pulse_save_back", {31'd0, bus.save}, 32'd1);
    checkVal("cnt_first", {30'd0, bus.err_count}, 32'd1);
    step(1'b0, 1'b0);

    // fail_in during ROLLBACK is ignored.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0);
    checkVal("cnt_second", {30'd0, bus.err_count}, 32'd2);

    // Saturation at 3.
    for (int i = 0; i < 3; i++) begin
      recover();
      checkVal($sformatf("cnt_sat%0d", i), {30'd0, bus.err_count}, {30'd0, satExp[i]});
    end

    // Failure on the final VERIFY cycle wins over completion.
    step(1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    checkVal("last_verify_fail", {31'd0, bus.rollBack}, 32'd1);
    repeat (6) step(1'b0, 1'b0);
    // First NORMAL cycle after VERIFY: a new recovery starts.
    step(1'b0, 1'b1);
    checkVal("first_normal_fail", {31'd0, bus.rollBack}, 32'd1);
    repeat (7) step(1'b0, 1'b0);

    // Two failed verify windows -> FATAL, sticky until reset.
    step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    checkVal("retry_rb", {31'd0, bus.rollBack}, 32'd1);
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    checkVal("fatal_set", {31'd0, bus.fatal}, 32'd1);
    for (int i = 0; i < 100; i++) step(1'b0, 1'(i % 2));
    checkVal("fatal_sticky", {30'd0, bus.fatal, bus.busy}, 32'h3);
    step(1'b1, 1'b0);
    checkVal("fatal_cleared", {28'd0, bus.fatal, bus.busy, bus.err_count}, 32'h4);
    repeat (3) step(1'b0, 1'b0);

    // Reset during the second ROLLBACK cycle.
    recover();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    checkVal("rst_mid_rb", {26'd0, bus.save, bus.rollBack, bus.subst, bus.busy, bus.err_count},
             32'h4);
    repeat (5) step(1'b0, 1'b0);
    checkVal("restart_normal", {31'd0, bus.save}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
